// File: rtl/serial_dac_tx_if.sv
// Sample-side and DAC-pin signals of the serial DAC transmitter.
// The generator drives tick/din/ch_en; the transmitter drives the pins and status.
interface serial_dac_tx_if #(
  parameter int N_CH       = 2,
  parameter int DATA_WIDTH = 12
);
  logic                       tick;
  logic [N_CH*DATA_WIDTH-1:0] din;
  logic [N_CH-1:0]            ch_en;
  logic                       sclk;
  logic                       sdi;
  logic                       cs_n;
  logic                       ldac_n;
  logic                       busy;
  logic                       done;
  logic                       overrun;

  modport master (output tick, din, ch_en,
                  input  sclk, sdi, cs_n, ldac_n, busy, done, overrun);
  modport slave  (input  tick, din, ch_en,
                  output sclk, sdi, cs_n, ldac_n, busy, done, overrun);
endinterface

// File: rtl/serial_dac_tx.sv
// Multi-channel SPI-style DAC transmitter: per tick, one {addr,data} frame per enabled
// channel, MSB first, then a common ldac_n strobe. All outputs registered.
module serial_dac_tx #(
  parameter int DATA_WIDTH  = 12,
  parameter int FRAME_BITS  = 16,
  parameter int N_CH        = 2,
  parameter int SCLK_DIV    = 2,
  parameter int CS_GAP      = 2,
  parameter int LDAC_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  serial_dac_tx_if.slave bus
);
  localparam int HW = FRAME_BITS - DATA_WIDTH;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int LW = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, LDAC} state_t;

  state_t                             state;
  logic [N_CH-1:0][DATA_WIDTH-1:0]    din_q;
  logic [N_CH-1:0][DATA_WIDTH-1:0]    din_w;
  logic [N_CH-1:0]                    en_q;
  logic [CW-1:0]                      ch;
  logic [FRAME_BITS-1:0]              shreg;
  logic [BW-1:0]                      bit_cnt;
  logic [DW-1:0]                      div_cnt;
  logic [GW-1:0]                      gap_cnt;
  logic [LW-1:0]                      ldac_cnt;
  logic                               empty_q;
  logic sclk_q, sdi_q, cs_n_q, ldac_n_q, busy_q, done_q, ovr_q;

  logic [CW-1:0]         first_ch, next_ch;
  logic                  next_vld;
  logic [FRAME_BITS-1:0] first_frame, next_frame;

  assign din_w = bus.din;

  // Lowest enabled channel at tick, and next enabled channel above the current one.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    next_vld = 1'b0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (bus.ch_en[i]) first_ch = CW'(i);
      if (en_q[i] && (CW'(i) > ch)) begin
        next_ch  = CW'(i);
        next_vld = 1'b1;
      end
    end
  end

  assign first_frame = {HW'(first_ch), din_w[first_ch]};
  assign next_frame  = {HW'(next_ch),  din_q[next_ch]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      din_q    <= '0;
      en_q     <= '0;
      ch       <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      ldac_cnt <= '0;
      empty_q  <= 1'b0;
      sclk_q   <= 1'b0;
      sdi_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      empty_q <= 1'b0;
      ovr_q   <= bus.tick && (state != IDLE);
      case (state)
        IDLE: begin
          done_q <= empty_q;
          if (bus.tick) begin
            din_q <= bus.din;
            en_q  <= bus.ch_en;
            if (bus.ch_en == '0) begin
              empty_q <= 1'b1;
            end else begin
              ch      <= first_ch;
              sdi_q   <= first_frame[FRAME_BITS-1];
              shreg   <= first_frame << 1;
              cs_n_q  <= 1'b0;
              sclk_q  <= 1'b0;
              div_cnt <= '0;
              bit_cnt <= '0;
              busy_q  <= 1'b1;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (div_cnt == DW'(SCLK_DIV-1)) begin
            div_cnt <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bit_cnt == BW'(FRAME_BITS-1)) begin
              sclk_q  <= 1'b0;
              cs_n_q  <= 1'b1;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              // sdi moves only on the falling sclk cycle
              sclk_q  <= 1'b0;
              sdi_q   <= shreg[FRAME_BITS-1];
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(CS_GAP-1)) begin
            if (next_vld) begin
              ch      <= next_ch;
              sdi_q   <= next_frame[FRAME_BITS-1];
              shreg   <= next_frame << 1;
              cs_n_q  <= 1'b0;
              div_cnt <= '0;
              bit_cnt <= '0;
              state   <= SHIFT;
            end else begin
              ldac_n_q <= 1'b0;
              ldac_cnt <= '0;
              state    <= LDAC;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        LDAC: begin
          if (ldac_cnt == LW'(LDAC_CYCLES-1)) begin
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= IDLE;
          end else begin
            ldac_cnt <= ldac_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.sdi     = sdi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.ldac_n  = ldac_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = ovr_q;
endmodule
